index_decoder_hold: RTL and testbench
=====================================

Name: index_decoder_hold

Overview:
- Sequential 3-to-8 index decoder; the consumer-side counterpart to the 8-to-3 priority encoder that produces a 3-bit index of the highest active request.
- Accepts a 3-bit code over a valid/ready handshake and drives a registered one-hot select line, held for a programmable minimum width.
- Keeps a sticky 8-bit pending vector of decoded indices, cleared per-bit by the downstream consumer.
- Counts duplicate events, i.e. a code arriving while its bit is already pending.

Parameters:
- HOLD_CYC, 2, number of cycles each one-hot select is held; legal range 1..15.
- CNT_W, 4, width of the saturating duplicate-event counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  3  encoded index to decode; 0..7.
- in_ready  output  1  block can accept in_code this cycle.
- clr_valid  input  1  request to clear one pending bit.
- clr_code  input  3  index of the pending bit to clear.
- dup_clr  input  1  synchronous clear of dup_cnt.
- onehot  output  8  registered decoded select; bit in_code set during hold.
- hold_active  output  1  high while onehot is non-zero, i.e. in HOLD state.
- pending  output  8  sticky vector of accepted indices not yet cleared.
- dup_cnt  output  CNT_W  saturating count of duplicate accepts.

Behaviour:
- Reset, asynchronous on rst_n low:
  - onehot=0, pending=0, dup_cnt=0, hold_active=0.
  - FSM=IDLE, hold counter=0; in_ready=1 as soon as rst_n is high.
- FSM states:
  - IDLE:
    - in_ready=1, onehot=0.
    - Accept = in_valid && in_ready, evaluated at the edge.
    - On accept: go to HOLD, onehot <= 1<<in_code, hold counter <= 0.
  - HOLD:
    - onehot constant.
    - Hold counter increments each cycle.
    - in_ready=1 only when hold counter == HOLD_CYC-1 (final hold cycle); otherwise 0.
  - In the final hold cycle:
    - If accept: stay in HOLD, onehot <= 1<<new code, counter <= 0. Back-to-back, no zero gap.
    - Else: go to IDLE, onehot <= 0.
- HOLD_CYC=1: in_ready is permanently 1; each accept produces a one-cycle onehot; continuous accepts give one code per cycle.
- Latency: code accepted at edge N appears on onehot in cycle N+1, for exactly HOLD_CYC cycles unless followed back-to-back.
- in_valid while in_ready=0: not accepted and not stored. The upstream holds the code until accepted.
- Pending vector, per bit i, next = (pending[i] & ~clr_hit[i]) | set_hit[i]:
  - set_hit[i] = accept && in_code==i.
  - clr_hit[i] = clr_valid && clr_code==i.
  - Simultaneous set and clear of the same bit: set wins (bit stays 1).
  - Clearing a non-pending bit: no effect.
  - Pending updates on the same edge as onehot load.
- Duplicate counter:
  - On accept, if pending[in_code] was 1 before the edge: dup_cnt increments. This holds even if the same bit is cleared in the same cycle.
  - Saturates at 2^CNT_W-1; no wrap.
  - dup_clr has priority over increment; dup_cnt <= 0.
- clr_valid is independent of FSM state and of in_ready; always honoured.
- Reset asserted mid-HOLD: immediate return to reset values; any code in flight is lost.
- All outputs are driven from registers or from FSM state/counter only; no combinational path from in_valid/in_code to any output.

Test Plan (HOLD_CYC=2, CNT_W=4):
- Assert rst_n=0, then release -> onehot=8'h00, pending=8'h00, dup_cnt=0, in_ready=1, hold_active=0.
- Accept in_code=5 once -> next 2 cycles onehot=8'h20, hold_active=1, in_ready=0 then 1; third cycle onehot=8'h00; pending=8'h20.
- in_valid held with code 5 then code 2 presented in the final hold cycle:
  - onehot sequence 20,20,04,04,00.
  - pending=8'h24.
  - in_valid asserted during the first hold cycle is not accepted.
- pending[5]=1, accept code 5 -> dup_cnt=1. Accept code 5 sixteen more times -> dup_cnt saturates at 15. Pulse dup_clr -> dup_cnt=0. Apply dup_clr and a duplicate accept in the same cycle -> dup_cnt=0.
- Same cycle: clr_code=5 and accept code 5 with pending=8'h20 -> pending stays 8'h20, dup_cnt+1. Then clr_code=3 alone -> pending unchanged. Then clr_code=5 -> pending=8'h00.
- rst_n driven low asynchronously mid-HOLD with onehot=8'h80, pending=8'h81 -> outputs zero immediately, without waiting for clk. After release, in_ready=1 and the next accept of code 0 gives onehot=8'h01.

Source files
------------

// File: rtl/index_decoder_hold.sv
// Sequential 3-to-8 index decoder: a handshaked 3-bit code becomes a registered one-hot
// select held for HOLD_CYC cycles, with a sticky pending vector and a duplicate-event counter.
module index_decoder_hold #(
    parameter int HOLD_CYC = 2,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       in_code,
    output logic             in_ready,
    input  logic             clr_valid,
    input  logic [2:0]       clr_code,
    input  logic             dup_clr,
    output logic [7:0]       onehot,
    output logic             hold_active,
    output logic [7:0]       pending,
    output logic [CNT_W-1:0] dup_cnt
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [3:0]       LAST_CNT = 4'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] DUP_MAX  = '1;

    state_t           state_reg;
    logic [3:0]       hold_cnt_reg;
    logic [7:0]       onehot_reg;
    logic [7:0]       pending_reg;
    logic [7:0]       pending_next;
    logic [7:0]       set_hit;
    logic [7:0]       clr_hit;
    logic [CNT_W-1:0] dup_cnt_reg;
    logic             accept;

    // Ready depends only on state and counter, so no input reaches an output combinationally.
    assign in_ready    = (state_reg == IDLE) || (hold_cnt_reg == LAST_CNT);
    assign accept      = in_valid && in_ready;
    assign onehot      = onehot_reg;
    assign hold_active = (state_reg == HOLD);
    assign pending     = pending_reg;
    assign dup_cnt     = dup_cnt_reg;

    // Set wins over a same-cycle clear of the same bit.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pending
            assign set_hit[gi]      = accept && (in_code == 3'(gi));
            assign clr_hit[gi]      = clr_valid && (clr_code == 3'(gi));
            assign pending_next[gi] = (pending_reg[gi] & ~clr_hit[gi]) | set_hit[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            onehot_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg    <= HOLD;
                        onehot_reg   <= 8'h01 << in_code;
                        hold_cnt_reg <= '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt_reg == LAST_CNT) begin
                        if (accept) begin
                            onehot_reg   <= 8'h01 << in_code;
                            hold_cnt_reg <= '0;
                        end else begin
                            state_reg    <= IDLE;
                            onehot_reg   <= '0;
                            hold_cnt_reg <= '0;
                        end
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    onehot_reg   <= '0;
                    hold_cnt_reg <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    // Duplicate test uses the pre-edge pending bit, so a same-cycle clear still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dup_cnt_reg <= '0;
        end else if (dup_clr) begin
            dup_cnt_reg <= '0;
        end else if (accept && pending_reg[in_code] && (dup_cnt_reg != DUP_MAX)) begin
            dup_cnt_reg <= dup_cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_index_decoder_hold.sv
// Scoreboard bench for index_decoder_hold: a timeline model predicts outputs per cycle,
// a monitor pops and compares on each falling edge.
module tb_index_decoder_hold;

    localparam int HOLD_CYC = 2;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [2:0]       in_code = '0;
    logic             in_ready;
    logic             clr_valid = 1'b0;
    logic [2:0]       clr_code = '0;
    logic             dup_clr = 1'b0;
    logic [7:0]       onehot;
    logic             hold_active;
    logic [7:0]       pending;
    logic [CNT_W-1:0] dup_cnt;

    index_decoder_hold #(.HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
        .in_ready(in_ready), .clr_valid(clr_valid), .clr_code(clr_code),
        .dup_clr(dup_clr), .onehot(onehot), .hold_active(hold_active),
        .pending(pending), .dup_cnt(dup_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       oh;
        logic [7:0]       pend;
        logic [CNT_W-1:0] dup;
        logic             rdy;
        logic             hold;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: an accept at edge N shows its code for cycles N+1..N+HOLD_CYC.
    int               m_since;
    bit               m_active;
    logic [2:0]       m_code;
    logic [7:0]       m_pend;
    logic [CNT_W-1:0] m_dup;

    function automatic bit model_ready();
        return !m_active || (m_since >= HOLD_CYC);
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.oh   = (m_active && m_since >= 1 && m_since <= HOLD_CYC) ? (8'h01 << m_code) : 8'h00;
        e.pend = m_pend;
        e.dup  = m_dup;
        e.rdy  = model_ready();
        e.hold = (e.oh != 8'h00);
        return e;
    endfunction

    task automatic model_reset();
        m_since  = 0;
        m_active = 0;
        m_code   = '0;
        m_pend   = '0;
        m_dup    = '0;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("onehot", onehot, e.oh);
            chk("pending", pending, e.pend);
            chk("dup_cnt", 8'(dup_cnt), 8'(e.dup));
            chk("in_ready", 8'(in_ready), 8'(e.rdy));
            chk("hold_active", 8'(hold_active), 8'(e.hold));
        end
    end

    task automatic cycle(input bit v, input logic [2:0] c, input bit cv,
                         input logic [2:0] cc, input bit dc);
        bit         acc;
        logic [7:0] cmask;
        logic [7:0] smask;
        @(negedge clk);
        #1;
        in_valid  = v;
        in_code   = c;
        clr_valid = cv;
        clr_code  = cc;
        dup_clr   = dc;
        acc   = v && model_ready();
        cmask = cv ? (8'h01 << cc) : 8'h00;
        smask = acc ? (8'h01 << c) : 8'h00;
        @(posedge clk);
        if (dc) m_dup = '0;
        else if (acc && m_pend[c] && m_dup != {CNT_W{1'b1}}) m_dup = m_dup + 1'b1;
        m_pend = (m_pend & ~cmask) | smask;
        if (acc) begin
            m_active = 1;
            m_since  = 1;
            m_code   = c;
            $display("accept code=%0d pending=%h dup=%0d", c, m_pend, m_dup);
        end else if (m_active && m_since < 1000) begin
            m_since++;
        end
        #1;
        sbq.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 3'd0, 0, 3'd0, 0);
    endtask

    task automatic check_state(input string tag, input logic [7:0] oh, input logic [7:0] pd,
                               input logic [7:0] dc, input logic rdy);
        chk({tag, ".onehot"}, onehot, oh);
        chk({tag, ".pending"}, pending, pd);
        chk({tag, ".dup_cnt"}, 8'(dup_cnt), dc);
        chk({tag, ".in_ready"}, 8'(in_ready), 8'(rdy));
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_state("reset", 8'h00, 8'h00, 8'd0, 1'b1);
        chk("reset.hold_active", 8'(hold_active), 8'h00);

        // Single accept of code 5
        cycle(1, 3'd5, 0, 3'd0, 0);
        idle(3);
        check_state("single", 8'h00, 8'h20, 8'd0, 1'b1);

        // Held valid: rejected in first hold cycle, back-to-back code 2 in final cycle
        cycle(1, 3'd5, 0, 3'd0, 0);
        cycle(1, 3'd5, 0, 3'd0, 0);
        cycle(1, 3'd2, 0, 3'd0, 0);
        idle(3);
        check_state("b2b", 8'h00, 8'h24, 8'd1, 1'b1);

        // Duplicate counter saturation and clear priority
        cycle(0, 3'd0, 0, 3'd0, 1);
        for (int i = 0; i < 40; i++) cycle(1, 3'd5, 0, 3'd0, 0);
        idle(2);
        check_state("sat", 8'h00, 8'h24, 8'd15, 1'b1);
        cycle(0, 3'd0, 0, 3'd0, 1);
        check_state("dupclr", 8'h00, 8'h24, 8'd0, 1'b1);
        cycle(1, 3'd5, 0, 3'd0, 1);
        idle(2);
        check_state("dupclr_acc", 8'h00, 8'h24, 8'd0, 1'b1);

        // Set beats clear of same bit; clearing a non-pending bit does nothing
        cycle(0, 3'd0, 1, 3'd2, 0);
        cycle(1, 3'd5, 1, 3'd5, 0);
        idle(2);
        check_state("setwins", 8'h00, 8'h20, 8'd1, 1'b1);
        cycle(0, 3'd0, 1, 3'd3, 0);
        check_state("clr_np", 8'h00, 8'h20, 8'd1, 1'b1);
        cycle(0, 3'd0, 1, 3'd5, 0);
        check_state("clr5", 8'h00, 8'h00, 8'd1, 1'b1);

        // Asynchronous reset in the middle of a hold
        cycle(1, 3'd0, 0, 3'd0, 0);
        idle(2);
        cycle(1, 3'd7, 0, 3'd0, 0);
        check_state("prerst", 8'h80, 8'h81, 8'd1, 1'b0);
        @(negedge clk);
        #2;
        in_valid = 0;
        clr_valid = 0;
        dup_clr = 0;
        rst_n = 1'b0;
        #1;
        check_state("asyncrst", 8'h00, 8'h00, 8'd0, 1'b1);
        chk("asyncrst.hold_active", 8'(hold_active), 8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("postrst.in_ready", 8'(in_ready), 8'h01);
        cycle(1, 3'd0, 0, 3'd0, 0);
        check_state("postrst", 8'h01, 8'h01, 8'd0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 30) == 0));
        end
        idle(4);

        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
